memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- SEQ memory stage of the Y86-64 processor. Sits between execute and writeback: consumes vale/vala/valp from execute/decode/fetch and produces valm for writeback.
- Owns the byte-addressable data memory. Performs one 8-byte little-endian access per instruction.
- Keeps the sticky processor status register (AOK/HLT/ADR/INS) that stops further state updates once a fault or halt occurs.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; must be ≥16 and a multiple of 8.
- AW, 10, width of internal byte index; log2(MEM_BYTES).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- icode  in  4  instruction code of the current instruction.
- vale  in  64  ALU result; the address for rmmovq, mrmovq, pushq and call.
- vala  in  64  write data for rmmovq and pushq; the address for popq and ret.
- valp  in  64  next PC; write data for call.
- imem_error  in  1  fetch reported an instruction-memory address error.
- instr_invalid  in  1  fetch reported an illegal icode/ifun.
- valm  out  64  read data; combinational.
- dmem_error  out  1  combinational; the current access is out of range.
- stat  out  2  registered status: 0=AOK, 1=HLT, 2=ADR, 3=INS.
- halted  out  1  registered; 1 when stat≠AOK.

Behaviour:
- Reset (reset_n low, async): stat=AOK, halted=0. Memory array is NOT cleared; it is preloaded by bench/init only. No write occurs while reset_n is low, even if a posedge arrives.
- Access decode:
  - rmmovq(4): write vala to M[vale].
  - call(8): write valp to M[vale].
  - pushq(A): write vala to M[vale].
  - mrmovq(5): read M[vale].
  - ret(9), popq(B): read M[vala].
  - All other icodes: no access.
- Byte order: little-endian. Byte addr holds bits [7:0]; byte addr+7 holds bits [63:56]. Unaligned addresses are legal.
- Range check: an access is in range iff the full 64-bit address is ≤ MEM_BYTES-8. Compare in 64 bits with no truncation, so 0xFFFF_FFFF_FFFF_FFFC is out of range. No address wrap-around.
- dmem_error = 1 iff icode is a memory icode and the address is out of range. It is 0 for non-memory icodes.
- Read path: combinational from the current array contents. valm reflects the array value before the same-cycle posedge write; writeback samples it on negedge.
  - valm = 0 when there is no read, on a read with dmem_error, or when halted=1.
- Write path: on posedge, only when reset_n=1, halted=0, dmem_error=0 and the icode is a write icode. All 8 bytes are written in the same edge. A faulting write modifies no bytes.
- Status next-state, priority high→low:
  - imem_error → ADR
  - instr_invalid → INS
  - dmem_error → ADR
  - icode==0 (halt) → HLT
  - else AOK
- Status update: registered at posedge only while halted=0. Once non-AOK, stat and halted hold until reset. Later writes are suppressed and later errors do not overwrite the first cause.
- Simultaneous imem_error and a memory icode: stat=ADR and the write is suppressed.
- nop(1), irmovq, OPq, cmovxx and jXX: no memory effect; stat stays AOK.

Optional Feature:
- Macro MEM_ACCESS_CNT_EN.
- When defined, two extra output ports:
  - rd_count (32 bits): increments on each posedge with a successful, non-faulting read while not halted.
  - wr_count (32 bits): increments on each committed write.
  - Both reset to 0 and wrap from 0xFFFF_FFFF to 0.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- rmmovq then mrmovq: icode=4, vale=0x10, vala=0x1122334455667788, one posedge; then icode=5, vale=0x10 → valm=0x1122334455667788, byte M[0x10]=0x88, M[0x17]=0x11, stat=AOK.
- call then ret: icode=8, vale=0x3F8, valp=0x2A, posedge; then icode=9, vala=0x3F8 → valm=0x2A. Boundary address 0x3F8 (MEM_BYTES-8) is accepted; dmem_error=0.
- Out-of-range write: icode=A, vale=0x3F9, vala=0xDEAD → dmem_error=1. After the posedge, stat=ADR and halted=1; bytes 0x3F9..0x3FF are unchanged. A following valid rmmovq writes nothing.
- Priority and sticky: imem_error=1 with instr_invalid=1 → stat=ADR. A later icode=0 with both errors clear leaves stat=ADR until reset_n pulses low, after which stat=AOK and halted=0.
- Halt: icode=0 → stat=HLT after the posedge. A subsequent mrmovq gives valm=0 and stat stays HLT.
- Async reset mid-write: icode=4 at a valid address with reset_n asserted low before the posedge → memory unchanged, stat=AOK. With MEM_ACCESS_CNT_EN, wr_count=0.

Source files
------------

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 SEQ memory stage: data memory, access range check, sticky status
// Optional feature macro: MEM_ACCESS_CNT_EN adds rd_count/wr_count access counters.

module memory_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  icode,
    input  logic [63:0] vale,
    input  logic [63:0] vala,
    input  logic [63:0] valp,
    input  logic        imem_error,
    input  logic        instr_invalid,
    output logic [63:0] valm,
    output logic        dmem_error,
    output logic [1:0]  stat,
    output logic        halted
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] S_AOK = 2'd0;
    localparam logic [1:0] S_HLT = 2'd1;
    localparam logic [1:0] S_ADR = 2'd2;
    localparam logic [1:0] S_INS = 2'd3;

    // Highest legal start address of an 8-byte access, kept at full address width
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    logic [7:0]    mem [MEM_BYTES];

    logic          is_write;
    logic          is_read;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [63:0]   rd_data;
    logic          wr_en;
    logic          rd_ok;
    logic [1:0]    stat_next;

    // Decode which kind of access the current icode performs and where
    always_comb begin
        is_write = 1'b0;
        is_read  = 1'b0;
        addr     = vale;
        wdata    = vala;
        case (icode)
            I_RMMOVQ: is_write = 1'b1;
            I_PUSHQ:  is_write = 1'b1;
            I_CALL: begin
                is_write = 1'b1;
                wdata    = valp;
            end
            I_MRMOVQ: is_read = 1'b1;
            I_RET, I_POPQ: begin
                is_read = 1'b1;
                addr    = vala;
            end
            default: begin
                is_write = 1'b0;
                is_read  = 1'b0;
            end
        endcase
    end

    // No wrap-around: the whole 64-bit address must leave room for 8 bytes
    assign in_range   = (addr <= MAX_ADDR);
    assign dmem_error = (is_write | is_read) & ~in_range;
    assign idx        = addr[AW-1:0];

    // Little-endian gather of the 8 bytes starting at idx (pre-write contents)
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 8; k++) begin
            rd_data[8*k +: 8] = mem[idx + AW'(k)];
        end
    end

    assign rd_ok = is_read & ~dmem_error & ~halted;
    assign valm  = rd_ok ? rd_data : 64'd0;

    // A write commits only for a clean, non-halted, in-range write instruction
    assign wr_en = reset_n & ~halted & is_write & ~dmem_error & ~imem_error & ~instr_invalid;

    // Status cause priority: fetch address error, illegal instruction, data address error, halt
    always_comb begin
        stat_next = S_AOK;
        if (imem_error) begin
            stat_next = S_ADR;
        end else if (instr_invalid) begin
            stat_next = S_INS;
        end else if (dmem_error) begin
            stat_next = S_ADR;
        end else if (icode == I_HALT) begin
            stat_next = S_HLT;
        end
    end

    // Data memory write port: all 8 bytes land on the same edge; array is never reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                mem[idx + AW'(k)] <= wdata[8*k +: 8];
            end
        end
    end

    // Sticky status: frozen at the first non-AOK cause until reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat   <= S_AOK;
            halted <= 1'b0;
        end else if (!halted) begin
            stat   <= stat_next;
            halted <= (stat_next != S_AOK);
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    // Access counters: successful reads and committed writes, free-running with wrap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else begin
            if (rd_ok) begin
                rd_count <= rd_count + 32'd1;
            end
            if (wr_en) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage against a byte-array reference model

module tb_memory_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic [63:0] vale = '0;
    logic [63:0] vala = '0;
    logic [63:0] valp = '0;
    logic        imem_error = 1'b0;
    logic        instr_invalid = 1'b0;
    logic [63:0] valm;
    logic        dmem_error;
    logic [1:0]  stat;
    logic        halted;
`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    memory_stage #(.MEM_BYTES(1024), .AW(10)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .icode(icode),
        .vale(vale),
        .vala(vala),
        .valp(valp),
        .imem_error(imem_error),
        .instr_invalid(instr_invalid),
        .valm(valm),
        .dmem_error(dmem_error),
        .stat(stat),
        .halted(halted)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] valm;
        logic        derr;
        logic [1:0]  stat;
        logic        halted;
        logic [31:0] rd;
        logic [31:0] wr;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  mm [1024];
    logic [1:0]  m_stat = 2'd0;
    logic [31:0] m_rd = 0;
    logic [31:0] m_wr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are settled by the falling edge, compare against the oldest expectation
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("valm", valm, e.valm);
            chk("dmem_error", 64'(dmem_error), 64'(e.derr));
            chk("stat", 64'(stat), 64'(e.stat));
            chk("halted", 64'(halted), 64'(e.halted));
`ifdef MEM_ACCESS_CNT_EN
            chk("rd_count", 64'(rd_count), 64'(e.rd));
            chk("wr_count", 64'(wr_count), 64'(e.wr));
`endif
        end
    end

    // One instruction per cycle: drive, predict the combinational outputs, then advance the model
    task automatic step(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, input logic ie, input logic ii, input logic rst);
        bit        wr, rd, halt_now, inr;
        logic [63:0] ad, rv, wd;
        logic [1:0]  nxt;
        exp_t        x;
        @(posedge clock);
        #1;
        icode = ic; vale = e; vala = a; valp = p;
        imem_error = ie; instr_invalid = ii; reset_n = rst;
        if (!rst) begin
            m_stat = 2'd0; m_rd = 0; m_wr = 0;
        end
        halt_now = (m_stat != 2'd0);
        wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        ad = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
        inr = (ad <= 64'd1016);
        wd = (ic == 4'h8) ? p : a;
        rv = 64'd0;
        if (rd && inr && !halt_now) begin
            for (int k = 0; k < 8; k++) rv[8*k +: 8] = mm[int'(ad) + k];
        end
        x.valm = rv;
        x.derr = (wr || rd) && !inr;
        x.stat = m_stat;
        x.halted = halt_now;
        x.rd = m_rd;
        x.wr = m_wr;
        sb.push_back(x);
        if (rst && !halt_now) begin
            if (ie)                  nxt = 2'd2;
            else if (ii)             nxt = 2'd3;
            else if (x.derr)         nxt = 2'd2;
            else if (ic == 4'h0)     nxt = 2'd1;
            else                     nxt = 2'd0;
            if (wr && inr && !ie && !ii) begin
                for (int k = 0; k < 8; k++) mm[int'(ad) + k] = wd[8*k +: 8];
                m_wr++;
            end
            if (rd && inr) m_rd++;
            m_stat = nxt;
        end
    endtask

    task automatic op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
        step(ic, e, a, p, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(4'h1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0]  ic;
        logic [63:0] ad, d;
        bit          ie, ii;

        // Reset state, then fill the whole array with known data
        do_reset();
        do_reset();
        for (int a = 0; a <= 1016; a += 8) begin
            op(4'h4, 64'(a), {$urandom, $urandom}, 64'd0);
        end

        // rmmovq then mrmovq, plus unaligned reads exposing byte 0x10 and byte 0x17
        op(4'h4, 64'h10, 64'h1122334455667788, 64'd0);
        op(4'h5, 64'h10, 64'd0, 64'd0);
        op(4'h5, 64'h17, 64'd0, 64'd0);
        op(4'h5, 64'h09, 64'd0, 64'd0);

        // call then ret at the last legal address
        op(4'h8, 64'h3F8, 64'd0, 64'h2A);
        op(4'h9, 64'd0, 64'h3F8, 64'd0);
        op(4'hB, 64'd0, 64'h3F8, 64'd0);

        // Out-of-range push, then a suppressed rmmovq, then confirm nothing moved
        op(4'hA, 64'h3F9, 64'hDEAD, 64'd0);
        op(4'h4, 64'h20, 64'hCAFE, 64'd0);
        op(4'h5, 64'h20, 64'd0, 64'd0);
        do_reset();
        op(4'h5, 64'h3F8, 64'd0, 64'd0);
        op(4'h5, 64'h20, 64'd0, 64'd0);

        // Huge address must not wrap into range
        op(4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0);
        do_reset();

        // Priority and stickiness
        step(4'h4, 64'h30, 64'h55, 64'd0, 1'b1, 1'b1, 1'b1);
        op(4'h0, 64'd0, 64'd0, 64'd0);
        op(4'h5, 64'h30, 64'd0, 64'd0);
        do_reset();
        op(4'h5, 64'h30, 64'd0, 64'd0);
        step(4'h6, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
        op(4'h0, 64'd0, 64'd0, 64'd0);
        do_reset();

        // Halt, then a read returns zero
        op(4'h0, 64'd0, 64'd0, 64'd0);
        op(4'h5, 64'h10, 64'd0, 64'd0);
        op(4'h5, 64'h10, 64'd0, 64'd0);

        // Reset asserted before the write edge: no write, status back to AOK
        step(4'h4, 64'h40, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b0, 1'b0);
        op(4'h5, 64'h40, 64'd0, 64'd0);

        // Randomised traffic with occasional faults; reset whenever the model has stopped
        for (int n = 0; n < 700; n++) begin
            if (m_stat != 2'd0 && ($urandom % 3) != 0) begin
                do_reset();
            end else begin
                ic = 4'($urandom_range(0, 11));
                if (ic == 4'h0 && ($urandom % 4) != 0) ic = 4'h1;
                case ($urandom % 16)
                    0: ad = 64'($urandom_range(1017, 1023));
                    1: ad = {$urandom, $urandom} | 64'h400;
                    default: ad = 64'($urandom_range(0, 1016));
                endcase
                d  = {$urandom, $urandom};
                ie = ($urandom % 50) == 0;
                ii = ($urandom % 50) == 0;
                step(ic, ad, (ic == 4'h9 || ic == 4'hB) ? ad : d, {$urandom, $urandom}, ie, ii, 1'b1);
            end
        end

        op(4'h1, 64'd0, 64'd0, 64'd0);
        @(posedge clock);
        @(posedge clock);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
